// File: rtl/ram512_x16.sv
// ---------------------------------------------------------------------------
// ram512_x16 -- 512-word x 16-bit read/write memory.
//
// Organised as 2^(ADDR_W-6) banks of 64 words. Each bank holds 8 groups of
// 8 registers, mirroring the classic RAM8 -> RAM64 -> RAM512 composition.
// The write enable is decoded level by level (bank, group, register) and
// the read data is multiplexed back up the same hierarchy.
//
// Ports:
//   clk      in   1       system clock; writes happen on the rising edge
//   reset    in   1       asynchronous active-high clear of every word
//   in       in   WIDTH   write data
//   address  in   ADDR_W  word address, shared by read and write
//   load     in   1       write enable, active-high
//   out      out  WIDTH   combinational read of the word at address
// ---------------------------------------------------------------------------
module ram512_x16 #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] address,
    input  logic              load,
    output logic [WIDTH-1:0]  out
);

    localparam int BW    = ADDR_W - 6;   // bank-select bits
    localparam int NBANK = 1 << BW;

    // Address fields: bank / group within bank / register within group.
    logic [BW-1:0] bank_a;
    logic [2:0]    group_a;
    logic [2:0]    reg_a;

    assign bank_a  = address[ADDR_W-1:6];
    assign group_a = address[5:3];
    assign reg_a   = address[2:0];

    // Read-back taps at each level of the hierarchy.
    logic [NBANK-1:0][7:0][7:0][WIDTH-1:0] word_rd;
    logic [NBANK-1:0][7:0][WIDTH-1:0]      group_rd;
    logic [NBANK-1:0][WIDTH-1:0]           bank_rd;

    genvar gi, gj, gk;
    generate
        for (gi = 0; gi < NBANK; gi++) begin : g_bank
            localparam logic [BW-1:0] BANK_ID = BW'(gi);
            logic bank_we;

            assign bank_we = load && (bank_a == BANK_ID);

            for (gj = 0; gj < 8; gj++) begin : g_group
                localparam logic [2:0] GROUP_ID = 3'(gj);
                logic group_we;

                assign group_we = bank_we && (group_a == GROUP_ID);

                for (gk = 0; gk < 8; gk++) begin : g_reg
                    localparam logic [2:0] REG_ID = 3'(gk);
                    logic             word_we;
                    logic [WIDTH-1:0] word_d;
                    logic [WIDTH-1:0] word_q;

                    assign word_we = group_we && (reg_a == REG_ID);
                    assign word_d  = word_we ? in : word_q;

                    // Reset wins over load: while reset is high the word
                    // is held at zero and any write is discarded.
                    always_ff @(posedge clk or posedge reset) begin
                        if (reset) begin
                            word_q <= '0;
                        end else begin
                            word_q <= word_d;
                        end
                    end

                    assign word_rd[gi][gj][gk] = word_q;
                end

                // RAM8 level: pick the register inside this group.
                assign group_rd[gi][gj] = word_rd[gi][gj][reg_a];
            end

            // RAM64 level: pick the group inside this bank.
            assign bank_rd[gi] = group_rd[gi][group_a];
        end
    endgenerate

    // Top level: pick the bank. Purely combinational, so an address change
    // is visible on out without waiting for a clock edge, and a write shows
    // up only after the edge that stores it.
    assign out = bank_rd[bank_a];

endmodule

// File: tb/tb_ram512_x16.sv
// ---------------------------------------------------------------------------
// tb_ram512_x16 -- self-checking bench for ram512_x16.
//
// A table of {load, address, in, expected-before-edge, expected-after-edge}
// records is replayed one clock at a time; reset behaviour and the
// clock-free address switching are exercised by short hand-written
// sequences. One line is printed per transaction.
// ---------------------------------------------------------------------------
module tb_ram512_x16;

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic [8:0]  address;
    logic        load;
    logic [15:0] out;

    int n_checks = 0;
    int n_fail   = 0;

    ram512_x16 #(.WIDTH(16), .ADDR_W(9)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .address (address),
        .load    (load),
        .out     (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        ld;
        logic [8:0]  addr;
        logic [15:0] din;
        logic [15:0] exp_pre;
        logic [15:0] exp_post;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: out=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic ld, input int addr,
                       input logic [15:0] din, input logic [15:0] pre,
                       input logic [15:0] post);
        vec_t v;
        v.name     = name;
        v.ld       = ld;
        v.addr     = 9'(addr);
        v.din      = din;
        v.exp_pre  = pre;
        v.exp_post = post;
        vecs.push_back(v);
    endtask

    // Drive a vector on the falling edge, check before and after the
    // following rising edge.
    task automatic apply(input vec_t v);
        @(negedge clk);
        load    = v.ld;
        address = v.addr;
        in      = v.din;
        #1;
        check({v.name, "/pre"}, out, v.exp_pre);
        @(posedge clk);
        #1;
        check({v.name, "/post"}, out, v.exp_post);
        $display("txn %-14s load=%0d addr=%3d in=%h out=%h", v.name, v.ld,
                 v.addr, v.din, out);
    endtask

    task automatic run_table();
        foreach (vecs[i]) apply(vecs[i]);
        vecs.delete();
    endtask

    task automatic peek(input string name, input int addr,
                        input logic [15:0] exp);
        address = 9'(addr);
        #1;
        check(name, out, exp);
        $display("txn %-14s addr=%3d out=%h", name, address, out);
    endtask

    logic [15:0] pat [8];

    initial begin
        pat = '{16'h0000, 16'hFFFF, 16'h00FF, 16'hFF00,
                16'h0F0F, 16'hF0F0, 16'h3333, 16'hCCCC};

        reset   = 1'b0;
        load    = 1'b0;
        in      = 16'h0000;
        address = 9'd0;

        // Initial reset.
        #3 reset = 1'b1;
        peek("por_a0", 0, 16'h0000);
        peek("por_a511", 511, 16'h0000);
        @(negedge clk);
        reset = 1'b0;

        // Reset clears memory: write FFFF to 5, then pulse reset between edges.
        add("w5_ffff", 1'b1, 5, 16'hFFFF, 16'h0000, 16'hFFFF);
        run_table();
        @(negedge clk);
        load    = 1'b0;
        address = 9'd5;
        #1 check("a5_before_rst", out, 16'hFFFF);
        reset = 1'b1;
        peek("a5_in_rst", 5, 16'h0000);
        reset = 1'b0;
        #1;
        peek("rst_a0", 0, 16'h0000);
        peek("rst_a100", 100, 16'h0000);
        peek("rst_a511", 511, 16'h0000);

        // Bank 0 write and sweep.
        for (int i = 0; i < 8; i++)
            add($sformatf("b0_wr%0d", i), 1'b1, i, pat[i], 16'h0000, pat[i]);
        for (int i = 0; i < 8; i++)
            add($sformatf("b0_rd%0d", i), 1'b0, i, 16'hABCD, pat[i], pat[i]);
        run_table();

        // Load gating.
        add("w2_1234", 1'b1, 2, 16'h1234, 16'h00FF, 16'h1234);
        for (int i = 0; i < 3; i++)
            add($sformatf("gate%0d", i), 1'b0, 2, 16'h00FF, 16'h1234, 16'h1234);
        add("gate_a1", 1'b0, 1, 16'h00FF, 16'hFFFF, 16'hFFFF);
        add("gate_a3", 1'b0, 3, 16'h00FF, 16'hFF00, 16'hFF00);
        run_table();

        // Cross-bank addressing.
        add("w100", 1'b1, 100, 16'h0F0F, 16'h0000, 16'h0F0F);
        add("w256", 1'b1, 256, 16'hF0F0, 16'h0000, 16'hF0F0);
        add("w129", 1'b1, 129, 16'h3333, 16'h0000, 16'h3333);
        add("w250", 1'b1, 250, 16'hCCCC, 16'h0000, 16'hCCCC);
        add("w511", 1'b1, 511, 16'hFFFF, 16'h0000, 16'hFFFF);
        add("w500", 1'b1, 500, 16'h0000, 16'h0000, 16'h0000);
        add("r100", 1'b0, 100, 16'h1111, 16'h0F0F, 16'h0F0F);
        add("r256", 1'b0, 256, 16'h1111, 16'hF0F0, 16'hF0F0);
        add("r129", 1'b0, 129, 16'h1111, 16'h3333, 16'h3333);
        add("r250", 1'b0, 250, 16'h1111, 16'hCCCC, 16'hCCCC);
        add("r511", 1'b0, 511, 16'h1111, 16'hFFFF, 16'hFFFF);
        add("r500", 1'b0, 500, 16'h1111, 16'h0000, 16'h0000);
        add("r4_bank0", 1'b0, 4, 16'h1111, 16'h0F0F, 16'h0F0F);
        add("r68_bank1", 1'b0, 68, 16'h1111, 16'h0000, 16'h0000);
        add("r36_bank0", 1'b0, 36, 16'h1111, 16'h0000, 16'h0000);
        run_table();

        // Read timing: old value before the edge, new value after.
        add("w3_aaaa", 1'b1, 3, 16'hAAAA, 16'hFF00, 16'hAAAA);
        add("w3_5555", 1'b1, 3, 16'h5555, 16'hAAAA, 16'h5555);
        run_table();

        // Address switching with no clock edge in between.
        @(negedge clk);
        load = 1'b0;
        in   = 16'h0000;
        peek("sw_a3", 3, 16'h5555);
        peek("sw_a511", 511, 16'hFFFF);
        peek("sw_a3_again", 3, 16'h5555);

        // Reset priority over load.
        @(negedge clk);
        reset   = 1'b1;
        load    = 1'b1;
        in      = 16'hBEEF;
        address = 9'd42;
        #1 check("rp_a42_pre", out, 16'h0000);
        @(posedge clk);
        #1 check("rp_a42_post", out, 16'h0000);
        $display("txn rst_prio       load=1 addr= 42 in=beef out=%h", out);
        @(negedge clk);
        reset = 1'b0;
        load  = 1'b0;
        add("rp_a42_hold", 1'b0, 42, 16'hBEEF, 16'h0000, 16'h0000);
        add("rp_a511", 1'b0, 511, 16'hBEEF, 16'h0000, 16'h0000);
        add("rp_a3", 1'b0, 3, 16'hBEEF, 16'h0000, 16'h0000);
        // Normal writes resume after release.
        add("rp_w42", 1'b1, 42, 16'h1357, 16'h0000, 16'h1357);
        run_table();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
